// File: rtl/wired_rob_alloc.sv
// wired_rob_alloc: reorder-buffer id allocator with head/tail/count tracking,
// two-wide dispatch allocation, two-wide commit retire and a flush/drain FSM.
// Optional build macro WIRED_ROB_ALLOC_STALL_CNT_EN adds a saturating
// dispatch-stall cycle counter on perf_stall_o.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal operation, dispatch allocation allowed
// S_DRAIN | flush in progress, dispatch blocked, commit drains entries
module wired_rob_alloc #(
   parameter int ROB_LEN = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             p_req_i,
   output logic                   p_ready_o,
   output logic [2*ROB_LEN-1:0]   p_wrrid_o,
   input  logic [1:0]             c_retire_i,
   output logic [2*ROB_LEN-1:0]   c_rrrid_o,
   output logic [1:0]             c_valid_o,
   input  logic                   flush_i,
   output logic                   drain_o,
   output logic                   drain_done_o,
   output logic                   full_o,
   output logic                   empty_o
`ifdef WIRED_ROB_ALLOC_STALL_CNT_EN
   ,
   output logic [31:0]            perf_stall_o
`endif
);

   localparam int                 DEPTH   = 1 << ROB_LEN;
   localparam logic [ROB_LEN:0]   DEPTH_C = DEPTH;
   localparam logic [ROB_LEN:0]   CNT_TWO = 2;
   localparam logic [ROB_LEN-1:0] ID_ONE  = 1;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [ROB_LEN-1:0]   head_q, head_d;
   logic [ROB_LEN-1:0]   tail_q, tail_d;
   logic [ROB_LEN:0]     count_q, count_d;
   logic [1:0]           c_valid_q, c_valid_d;

   logic [1:0]           need;
   logic [1:0]           grant_need;
   logic [1:0]           ret_raw;
   logic [1:0]           ret;
   logic [ROB_LEN:0]     free_cnt;
   logic                 drain_done;

   // Dispatch grant: all-or-nothing against the registered count only.
   always_comb begin
      need       = {1'b0, p_req_i[0]} + {1'b0, p_req_i[1]};
      free_cnt   = DEPTH_C - count_q;
      p_ready_o  = rst_n && (state_q == S_RUN) && !flush_i &&
                   (free_cnt >= {{(ROB_LEN-1){1'b0}}, need});
      grant_need = p_ready_o ? need : 2'd0;
   end

   // Retire amount clamped to the entries actually held; pointer/count next.
   always_comb begin
      ret_raw = {1'b0, c_retire_i[0]} + {1'b0, c_retire_i[1]};
      if ({{(ROB_LEN-1){1'b0}}, ret_raw} > count_q) begin
         ret = count_q[1:0];
      end else begin
         ret = ret_raw;
      end
      count_d   = count_q + {{(ROB_LEN-1){1'b0}}, grant_need}
                          - {{(ROB_LEN-1){1'b0}}, ret};
      tail_d    = tail_q + {{(ROB_LEN-2){1'b0}}, grant_need};
      head_d    = head_q + {{(ROB_LEN-2){1'b0}}, ret};
      c_valid_d = {(count_d >= CNT_TWO), (count_d != '0)};
   end

   // Flush FSM next-state; a flush seen while draining is ignored.
   always_comb begin
      state_d    = state_q;
      drain_done = 1'b0;
      case (state_q)
         S_RUN: begin
            if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (count_d == '0) begin
               state_d    = S_RUN;
               drain_done = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // State, pointer and count registers; pointers survive a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         c_valid_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         c_valid_q <= c_valid_d;
      end
   end

   // Output decode from registered state.
   always_comb begin
      p_wrrid_o    = {tail_q + ID_ONE, tail_q};
      c_rrrid_o    = {head_q + ID_ONE, head_q};
      c_valid_o    = c_valid_q;
      drain_o      = (state_q == S_DRAIN);
      drain_done_o = drain_done;
      full_o       = (count_q == DEPTH_C);
      empty_o      = (count_q == '0);
   end

`ifdef WIRED_ROB_ALLOC_STALL_CNT_EN
   logic [31:0] stall_q;

   // Count cycles where dispatch wanted entries but was refused; saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if ((need != 2'd0) && !p_ready_o && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_wired_rob_alloc.sv
// Scoreboard bench for wired_rob_alloc: the stimulus process evaluates a
// queue-level reference model each cycle and pushes the expected outputs;
// a separate monitor pops them and compares against the DUT.
module tb_wired_rob_alloc;

   localparam int RL = 6;
   localparam int D  = 1 << RL;

   logic            clk;
   logic            rst_n;
   logic [1:0]      p_req_i;
   logic            p_ready_o;
   logic [2*RL-1:0] p_wrrid_o;
   logic [1:0]      c_retire_i;
   logic [2*RL-1:0] c_rrrid_o;
   logic [1:0]      c_valid_o;
   logic            flush_i;
   logic            drain_o;
   logic            drain_done_o;
   logic            full_o;
   logic            empty_o;
`ifdef WIRED_ROB_ALLOC_STALL_CNT_EN
   logic [31:0]     perf_stall_o;
`endif

   wired_rob_alloc #(.ROB_LEN(RL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p_req_i      (p_req_i),
      .p_ready_o    (p_ready_o),
      .p_wrrid_o    (p_wrrid_o),
      .c_retire_i   (c_retire_i),
      .c_rrrid_o    (c_rrrid_o),
      .c_valid_o    (c_valid_o),
      .flush_i      (flush_i),
      .drain_o      (drain_o),
      .drain_done_o (drain_done_o),
      .full_o       (full_o),
      .empty_o      (empty_o)
`ifdef WIRED_ROB_ALLOC_STALL_CNT_EN
      ,
      .perf_stall_o (perf_stall_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            ready;
      logic [2*RL-1:0] wr;
      logic [2*RL-1:0] rr;
      logic [1:0]      cv;
      logic            drain;
      logic            done;
      logic            full;
      logic            empty;
      logic [31:0]     stall;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: the ROB is just a count of occupied slots starting at
   // an absolute head sequence number; tail follows from head + count.
   int          m_cnt   = 0;
   int          m_head  = 0;
   bit          m_drain = 0;
   logic [31:0] m_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Drive one cycle of stimulus and push the model's expectation for it.
   task automatic cyc(input logic [1:0] req, input logic [1:0] rt, input logic fl, input bit rst);
      exp_t e;
      int   need, want, r, g, tl, nxt;
      bit   rdy;
      @(negedge clk);
      rst_n      = !rst;
      p_req_i    = req;
      c_retire_i = rt;
      flush_i    = fl;
      if (rst) begin
         m_cnt = 0; m_head = 0; m_drain = 0; m_stall = 0;
      end
      need = int'(req[0]) + int'(req[1]);
      want = int'(rt[0]) + int'(rt[1]);
      rdy  = !rst && !m_drain && !fl && ((D - m_cnt) >= need);
      tl   = (m_head + m_cnt) % D;
      r    = (want < m_cnt) ? want : m_cnt;
      g    = rdy ? need : 0;
      nxt  = m_cnt + g - r;
      e.ready = rdy;
      e.wr    = {RL'((tl + 1) % D), RL'(tl)};
      e.rr    = {RL'((m_head + 1) % D), RL'(m_head % D)};
      e.cv    = {(m_cnt >= 2), (m_cnt >= 1)};
      e.drain = m_drain;
      e.done  = !rst && m_drain && (nxt == 0);
      e.full  = (m_cnt == D);
      e.empty = (m_cnt == 0);
      e.stall = m_stall;
      exp_q.push_back(e);
      if (!rst) begin
         if (need > 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         m_cnt  = nxt;
         m_head = (m_head + r) % D;
         if (!m_drain && fl)           m_drain = 1;
         else if (m_drain && nxt == 0) m_drain = 0;
      end
   endtask

   // Monitor: every cycle the DUT presents its outputs, compare with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("p_ready",    32'(p_ready_o),    32'(e.ready));
            chk("p_wrrid",    32'(p_wrrid_o),    32'(e.wr));
            chk("c_rrrid",    32'(c_rrrid_o),    32'(e.rr));
            chk("c_valid",    32'(c_valid_o),    32'(e.cv));
            chk("drain",      32'(drain_o),      32'(e.drain));
            chk("drain_done", 32'(drain_done_o), 32'(e.done));
            chk("full",       32'(full_o),       32'(e.full));
            chk("empty",      32'(empty_o),      32'(e.empty));
`ifdef WIRED_ROB_ALLOC_STALL_CNT_EN
            chk("perf_stall", perf_stall_o,      e.stall);
`endif
         end
      end
   end

   initial begin
      logic [1:0] rq, rt;
      logic       fl;
      int         k;
      rst_n = 1'b0; p_req_i = 2'b00; c_retire_i = 2'b00; flush_i = 1'b0;
      cyc(2'b11, 2'b00, 1'b0, 1);
      cyc(2'b00, 2'b00, 1'b0, 1);
      // Double dispatch from empty, then retire both.
      cyc(2'b11, 2'b00, 1'b0, 0);
      cyc(2'b00, 2'b00, 1'b0, 0);
      cyc(2'b00, 2'b11, 1'b0, 0);
      // Walk head and tail to 63 while empty, then allocate across the wrap.
      cyc(2'b01, 2'b00, 1'b0, 0);
      for (int i = 0; i < 60; i++) cyc(2'b01, 2'b01, 1'b0, 0);
      cyc(2'b00, 2'b01, 1'b0, 0);
      cyc(2'b11, 2'b00, 1'b0, 0);
      // Retire clamped: count 2 -> 1 -> 0 with a double retire at count 1.
      cyc(2'b00, 2'b01, 1'b0, 0);
      cyc(2'b00, 2'b11, 1'b0, 0);
      cyc(2'b00, 2'b11, 1'b0, 0);
      // Reset in the middle of operation, then resume from empty.
      cyc(2'b11, 2'b00, 1'b0, 0);
      cyc(2'b11, 2'b01, 1'b0, 1);
      cyc(2'b00, 2'b00, 1'b0, 1);
      // Fill to 63, refuse a pair, accept a single, hit full.
      for (int i = 0; i < 31; i++) cyc(2'b11, 2'b00, 1'b0, 0);
      cyc(2'b01, 2'b00, 1'b0, 0);
      cyc(2'b11, 2'b00, 1'b0, 0);
      cyc(2'b01, 2'b00, 1'b0, 0);
      // Full: retire two with a request in the same cycle is not bypassed.
      cyc(2'b01, 2'b11, 1'b0, 0);
      cyc(2'b01, 2'b00, 1'b0, 0);
      // Retire down to 5, flush while retiring, dispatch held off in drain.
      for (int i = 0; i < 29; i++) cyc(2'b00, 2'b11, 1'b0, 0);
      cyc(2'b11, 2'b11, 1'b1, 0);
      cyc(2'b11, 2'b11, 1'b1, 0);
      cyc(2'b01, 2'b11, 1'b0, 0);
      cyc(2'b11, 2'b00, 1'b0, 0);
      // Flush at empty: one drain cycle then exit.
      cyc(2'b00, 2'b00, 1'b0, 0);
      cyc(2'b00, 2'b00, 1'b0, 0);
      cyc(2'b00, 2'b11, 1'b1, 0);
      cyc(2'b11, 2'b00, 1'b0, 0);
      cyc(2'b00, 2'b00, 1'b0, 0);
      // Randomized phases alternating dispatch-heavy and retire-heavy traffic.
      for (int ph = 0; ph < 8; ph++) begin
         for (int i = 0; i < 250; i++) begin
            k  = $urandom_range(0, 9);
            if (ph % 2 == 0) rq = (k < 6) ? 2'b11 : (k < 8) ? 2'b01 : 2'b00;
            else             rq = (k < 2) ? 2'b11 : (k < 4) ? 2'b01 : 2'b00;
            k  = $urandom_range(0, 9);
            if (ph % 2 == 0) rt = (k < 2) ? 2'b11 : (k < 4) ? 2'b01 : 2'b00;
            else             rt = (k < 6) ? 2'b11 : (k < 8) ? 2'b01 : 2'b00;
            fl = ($urandom_range(0, 29) == 0);
            cyc(rq, rt, fl, ($urandom_range(0, 499) == 0));
         end
      end
      @(negedge clk);
      #5;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wired_rob_alloc.md
WIRED_ROB_ALLOC -- requirements
Module: wired_rob_alloc

Interface
REQ-001 SHALL have parameter ROB_LEN, default 6: log2 of ROB depth (DEPTH = 2^ROB_LEN).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port p_req_i  input  2  dispatch lane requests; packed, bit1 only with bit0.
REQ-005 SHALL have port p_ready_o  output  1  allocation granted this cycle (combinational).
REQ-006 SHALL have port p_wrrid_o  output  2xROB_LEN  ROB ids for lane0/lane1 (tail, tail+1).
REQ-007 SHALL have port c_retire_i  input  2  commit retire lanes; packed, bit1 only with bit0.
REQ-008 SHALL have port c_rrrid_o  output  2xROB_LEN  ROB read ids for commit (head, head+1).
REQ-009 SHALL have port c_valid_o  output  2  registered: bit0 = count>=1, bit1 = count>=2.
REQ-010 SHALL have port flush_i  input  1  backend flush request, single-cycle pulse.
REQ-011 SHALL have port drain_o  output  1  high while in DRAIN state.
REQ-012 SHALL have port drain_done_o  output  1  one-cycle pulse on DRAIN exit.
REQ-013 SHALL have ports full_o / empty_o  output  1 each  count==DEPTH / count==0.

Function
REQ-014 SHALL hold head, tail (ROB_LEN bits, natural wrap) and count (ROB_LEN+1 bits).
REQ-015 SHALL compute need = p_req_i[0] + p_req_i[1]; free = DEPTH - count (registered count only, no same-cycle retire bypass).
REQ-016 SHALL assert p_ready_o iff state==RUN and free >= need; all-or-nothing, no partial grant.
REQ-017 SHALL, on grant with need>0, advance tail by need; p_wrrid_o valid regardless, equal {tail+1, tail}.
REQ-018 SHALL compute ret = c_retire_i[0] + c_retire_i[1], clamped to count; excess retire bits ignored.
REQ-019 SHALL advance head by ret and set count_next = count + granted_need - ret.
REQ-020 SHALL drive c_rrrid_o = {head+1, head}; c_valid_o registered from count_next.
REQ-021 SHALL implement FSM RUN/DRAIN: RUN --flush_i--> DRAIN; DRAIN --count_next==0--> RUN with drain_done_o pulsed that cycle.
REQ-022 SHALL block dispatch in the flush cycle and throughout DRAIN; retire continues so commit drains entries and restores rename state.
REQ-023 SHALL, if flush_i arrives with count==0 (or count reaching 0 same cycle), enter DRAIN one cycle then exit with drain_done_o.
REQ-024 SHALL ignore flush_i while already in DRAIN.
REQ-025 SHALL keep head/tail values across flush (no pointer reset); invariant tail - head == count mod DEPTH.

Reset
REQ-026 SHALL on rst_n low asynchronously set head=0, tail=0, count=0, state=RUN, c_valid_o=0, drain_done_o=0.
REQ-027 SHALL during reset drive p_ready_o=0, empty_o=1, full_o=0, drain_o=0; deassertion mid-operation resumes from empty RUN.

Configuration
REQ-028 SHALL with WIRED_ROB_ALLOC_STALL_CNT_EN defined add output perf_stall_o (32 bits) counting cycles with need>0 and p_ready_o=0, saturating at 2^32-1, reset to 0.
REQ-029 SHALL without WIRED_ROB_ALLOC_STALL_CNT_EN omit the port and counter entirely.

Verification
REQ-030 SHALL test reset then p_req_i=2'b11 -> p_ready_o=1, p_wrrid_o={1,0}; next cycle c_valid_o=2'b11, tail=2.
REQ-031 SHALL test fill to count=63 (ROB_LEN=6), p_req_i=2'b11 -> p_ready_o=0; p_req_i=2'b01 -> grant, full_o=1 next cycle.
REQ-032 SHALL test count=64 with c_retire_i=2'b11 and p_req_i=2'b01 same cycle -> no grant; next cycle count=62, grant.
REQ-033 SHALL test wrap: head=tail=63, allocate 2 -> p_wrrid_o={0,63}, tail=1.
REQ-034 SHALL test flush_i at count=5, retire 2/cycle -> dispatch blocked, drain_done_o pulses in cycle count_next reaches 0, RUN after.
REQ-035 SHALL test count=1 with c_retire_i=2'b11 -> head advances 1, count=0, empty_o=1.
